id_ex_pipeline: RTL and testbench

ID_EX_PIPELINE -- requirements
Module: id_ex_pipeline

---
 rtl/id_ex_pipeline.sv | 96 +++++++++
 tb/tb_id_ex_pipeline.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_ex_pipeline                                                  |
// | Purpose  : ID/EX pipeline register with load-use bubble insertion,         |
// |            EX stall hold, branch flush and a saturating bubble counter.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module id_ex_pipeline #(
  parameter int          CTRL_W     = 9,
  parameter logic [15:0] BUBBLE_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_pc_plus4,
  input  logic [31:0]       id_read_data1,
  input  logic [31:0]       id_read_data2,
  input  logic [31:0]       id_immediate,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_func3,
  input  logic [4:0]        id_alu_control,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_stall,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_pc_plus4,
  output logic [31:0]       ex_read_data1,
  output logic [31:0]       ex_read_data2,
  output logic [31:0]       ex_immediate,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_func3,
  output logic [4:0]        ex_alu_control,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic              hazard_stall,
  output logic              if_id_hold,
  output logic [15:0]       bubble_count
);

  // Bit position of MEM_READ inside the packed control bundle.
  localparam int c_mem_read_bit = 5;

  logic w_hazard;

  assign w_hazard = id_valid && ex_valid && ex_ctrl[c_mem_read_bit] &&
                    (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign hazard_stall = w_hazard;
  assign if_id_hold   = w_hazard | ex_stall;

  // Reset, flush and bubble all clear the stage; only the bubble is counted.
  always_ff @(posedge clk) begin
    if (rst || flush || (!ex_stall && w_hazard)) begin
      ex_pc          <= '0;
      ex_pc_plus4    <= '0;
      ex_read_data1  <= '0;
      ex_read_data2  <= '0;
      ex_immediate   <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_func3       <= '0;
      ex_alu_control <= '0;
      ex_ctrl        <= '0;
      ex_valid       <= 1'b0;
    end else if (!ex_stall) begin
      ex_pc          <= id_pc;
      ex_pc_plus4    <= id_pc_plus4;
      ex_read_data1  <= id_read_data1;
      ex_read_data2  <= id_read_data2;
      ex_immediate   <= id_immediate;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_rd          <= id_rd;
      ex_func3       <= id_func3;
      ex_alu_control <= id_alu_control;
      ex_ctrl        <= id_valid ? id_ctrl : '0;
      ex_valid       <= id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= 16'd0;
    end else if (!flush && !ex_stall && w_hazard && (bubble_count != BUBBLE_MAX)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipeline.sv
`default_nettype none
// Bench for id_ex_pipeline: directed vectors against a cycle model of the
// EX stage, plus literal expectations for the documented scenarios.
module tb_id_ex_pipeline;

  typedef struct packed {
    logic [31:0] pc, pc4, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [4:0]  alu;
    logic [8:0]  ctrl;
    logic        valid;
  } ex_t;

  localparam logic [15:0] SAT_S = 16'd3;

  logic        clk = 1'b0;
  logic        rst, id_valid, flush, ex_stall;
  logic [31:0] id_pc, id_pc_plus4, id_read_data1, id_read_data2, id_immediate;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_control;
  logic [2:0]  id_func3;
  logic [8:0]  id_ctrl;

  logic [31:0] ex_pc, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_immediate;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_control;
  logic [2:0]  ex_func3;
  logic [8:0]  ex_ctrl;
  logic        ex_valid, hazard_stall, if_id_hold;
  logic [15:0] bubble_count;

  logic [31:0] s_pc, s_pc4, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd, s_alu;
  logic [2:0]  s_f3;
  logic [8:0]  s_ctrl;
  logic        s_valid, s_hz, s_hold;
  logic [15:0] s_count;

  always #5 clk = ~clk;

  id_ex_pipeline dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_immediate(id_immediate),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_func3(id_func3),
    .id_alu_control(id_alu_control), .id_ctrl(id_ctrl), .flush(flush), .ex_stall(ex_stall),
    .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_read_data1(ex_read_data1),
    .ex_read_data2(ex_read_data2), .ex_immediate(ex_immediate), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_func3(ex_func3), .ex_alu_control(ex_alu_control),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .hazard_stall(hazard_stall),
    .if_id_hold(if_id_hold), .bubble_count(bubble_count)
  );

  // Same stimulus, small saturation limit so the saturation rule is reachable quickly.
  id_ex_pipeline #(.CTRL_W(9), .BUBBLE_MAX(SAT_S)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_immediate(id_immediate),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_func3(id_func3),
    .id_alu_control(id_alu_control), .id_ctrl(id_ctrl), .flush(flush), .ex_stall(ex_stall),
    .ex_pc(s_pc), .ex_pc_plus4(s_pc4), .ex_read_data1(s_rd1),
    .ex_read_data2(s_rd2), .ex_immediate(s_imm), .ex_rs1(s_rs1),
    .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_func3(s_f3), .ex_alu_control(s_alu),
    .ex_ctrl(s_ctrl), .ex_valid(s_valid), .hazard_stall(s_hz),
    .if_id_hold(s_hold), .bubble_count(s_count)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  ex_t         m;
  logic [15:0] m_cnt, m_cnt_s;
  ex_t         id_in, dut_ex, dut_s_ex;
  logic        m_hz;
  logic        started = 1'b0;

  assign id_in = '{pc: id_pc, pc4: id_pc_plus4, rd1: id_read_data1, rd2: id_read_data2,
                   imm: id_immediate, rs1: id_rs1, rs2: id_rs2, rd: id_rd, f3: id_func3,
                   alu: id_alu_control, ctrl: (id_valid ? id_ctrl : 9'h000), valid: id_valid};
  assign dut_ex = {ex_pc, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_immediate,
                   ex_rs1, ex_rs2, ex_rd, ex_func3, ex_alu_control, ex_ctrl, ex_valid};
  assign dut_s_ex = {s_pc, s_pc4, s_rd1, s_rd2, s_imm, s_rs1, s_rs2, s_rd, s_f3, s_alu,
                     s_ctrl, s_valid};
  // A load (MEM_READ is bit 5) in EX whose nonzero destination feeds the decode instruction.
  assign m_hz = id_valid && m.valid && m.ctrl[5] && (m.rd != 5'd0) &&
                ((m.rd == id_rs1) || (m.rd == id_rs2));

  always @(posedge clk) begin
    if (rst) begin
      m <= '0; m_cnt <= 16'd0; m_cnt_s <= 16'd0;
    end else if (flush) begin
      m <= '0;
    end else if (!ex_stall) begin
      if (m_hz) begin
        m <= '0;
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        if (m_cnt_s < SAT_S) m_cnt_s <= m_cnt_s + 16'd1;
      end else begin
        m <= id_in;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ex_state", 256'(dut_ex), 256'(m));
      chk("hazard", 256'(hazard_stall), 256'(m_hz));
      chk("if_id_hold", 256'(if_id_hold), 256'(m_hz | ex_stall));
      chk("bubble_count", 256'(bubble_count), 256'(m_cnt));
      chk("sat_state", 256'(dut_s_ex), 256'(m));
      chk("sat_count", 256'(s_count), 256'(m_cnt_s));
      chk("ctrl_zero_bubble", 256'(ex_valid == 1'b0 && ex_ctrl != 9'h000), 256'(0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [8:0] ctrl, input logic v);
    id_pc = pc; id_pc_plus4 = pc + 32'd4;
    id_read_data1 = pc ^ 32'hA5A5_0000; id_read_data2 = ~pc;
    id_immediate = {pc[15:0], 11'd0, rd};
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_func3 = rd[2:0]; id_alu_control = rs1 ^ rs2;
    id_ctrl = ctrl; id_valid = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [8:0] C_ADD = 9'h100;
  localparam logic [8:0] C_LW  = 9'h1A0;

  initial begin
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    set_id(32'h0, 5'd0, 5'd0, 5'd0, 9'h000, 1'b0);
    tick(); tick();
    started = 1'b1;
    chk("reset_valid", 256'(ex_valid), 256'(0));
    chk("reset_count", 256'(bubble_count), 256'(0));
    rst = 1'b0;

    // simple load
    set_id(32'h100, 5'd1, 5'd2, 5'd5, C_ADD, 1'b1);
    tick();
    chk("load_pc", 256'(ex_pc), 256'(32'h100));
    chk("load_rd", 256'(ex_rd), 256'(5));
    chk("load_valid", 256'(ex_valid), 256'(1));
    chk("load_ctrl", 256'(ex_ctrl), 256'(9'h100));

    // load-use: lw x5 then add using x5
    set_id(32'h104, 5'd1, 5'd2, 5'd5, C_LW, 1'b1);
    tick();
    set_id(32'h108, 5'd3, 5'd5, 5'd6, C_ADD, 1'b1);
    #1;
    chk("lu_hazard", 256'(hazard_stall), 256'(1));
    chk("lu_hold", 256'(if_id_hold), 256'(1));
    tick();
    chk("bubble_valid", 256'(ex_valid), 256'(0));
    chk("bubble_ctrl", 256'(ex_ctrl), 256'(0));
    chk("bubble_cnt1", 256'(bubble_count), 256'(1));
    chk("bubble_nohz", 256'(hazard_stall), 256'(0));
    tick();
    chk("held_enters_valid", 256'(ex_valid), 256'(1));
    chk("held_enters_pc", 256'(ex_pc), 256'(32'h108));

    // load with rd=x0 never stalls
    set_id(32'h10C, 5'd0, 5'd0, 5'd0, C_LW, 1'b1);
    tick();
    set_id(32'h110, 5'd0, 5'd0, 5'd7, C_ADD, 1'b1);
    #1;
    chk("x0_nohz", 256'(hazard_stall), 256'(0));
    tick();
    chk("x0_pc", 256'(ex_pc), 256'(32'h110));
    chk("x0_cnt", 256'(bubble_count), 256'(1));

    // EX stall for 3 cycles with changing decode inputs
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(32'h300 + 32'(i * 4), 5'd7, 5'd7, 5'(i + 1), C_LW, 1'b1);
      tick();
      chk("stall_pc", 256'(ex_pc), 256'(32'h110));
      chk("stall_rd", 256'(ex_rd), 256'(7));
      chk("stall_hold", 256'(if_id_hold), 256'(1));
      chk("stall_cnt", 256'(bubble_count), 256'(1));
    end
    ex_stall = 1'b0;

    // flush beats stall and hazard
    set_id(32'h200, 5'd1, 5'd2, 5'd5, C_LW, 1'b1);
    tick();
    set_id(32'h204, 5'd5, 5'd0, 5'd8, C_ADD, 1'b1);
    flush = 1'b1; ex_stall = 1'b1;
    #1;
    chk("flush_hz", 256'(hazard_stall), 256'(1));
    tick();
    chk("flush_valid", 256'(ex_valid), 256'(0));
    chk("flush_ctrl", 256'(ex_ctrl), 256'(0));
    chk("flush_cnt", 256'(bubble_count), 256'(1));
    flush = 1'b0; ex_stall = 1'b0;

    // five more load-use bubbles: full counter 6, small counter pinned at 3
    for (int i = 0; i < 5; i++) begin
      set_id(32'h400 + 32'(i * 8), 5'd1, 5'd2, 5'd9, C_LW, 1'b1);
      tick();
      set_id(32'h404 + 32'(i * 8), 5'd9, 5'd3, 5'd10, C_ADD, 1'b1);
      tick();
    end
    chk("sat_full", 256'(bubble_count), 256'(6));
    chk("sat_small", 256'(s_count), 256'(3));

    // invalid decode slot loads data but never control
    set_id(32'h500, 5'd1, 5'd2, 5'd11, 9'h1FF, 1'b0);
    tick();
    tick();
    chk("inv_valid", 256'(ex_valid), 256'(0));
    chk("inv_ctrl", 256'(ex_ctrl), 256'(0));
    chk("inv_pc", 256'(ex_pc), 256'(32'h500));

    // reset in the middle of a stall discards everything
    set_id(32'h600, 5'd1, 5'd2, 5'd12, C_LW, 1'b1);
    tick();
    ex_stall = 1'b1; rst = 1'b1;
    tick();
    chk("rst_stall_valid", 256'(ex_valid), 256'(0));
    chk("rst_stall_pc", 256'(ex_pc), 256'(0));
    chk("rst_stall_cnt", 256'(bubble_count), 256'(0));
    rst = 1'b0; ex_stall = 1'b0;
    set_id(32'h700, 5'd1, 5'd2, 5'd13, C_ADD, 1'b1);
    tick();
    chk("post_rst_pc", 256'(ex_pc), 256'(32'h700));

    // mixed traffic checked against the model
    for (int i = 0; i < 60; i++) begin
      set_id($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 9'($urandom), 1'($urandom_range(0, 3) != 0));
      flush    = ($urandom_range(0, 7) == 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 29) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
